// File: rtl/uibi_arbiter.sv
// Round-robin, grant-until-done arbiter sharing one UIBI slave port between NMASTER masters.
// Optional forced completion of stalled transactions is enabled by defining UIBI_ARB_TIMEOUT_EN.
module uibi_arbiter #(
  parameter int NMASTER = 2,
  parameter int XLEN    = 32,
  parameter int NUM_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NMASTER-1:0]       m_req,
  input  logic [NMASTER-1:0]       m_wen,
  input  logic [3*NMASTER-1:0]     m_mode,
  input  logic [XLEN*NMASTER-1:0]  m_addr,
  input  logic [XLEN*NMASTER-1:0]  m_dat_o,
  input  logic [NUM_W*NMASTER-1:0] m_num,
  output logic [NMASTER-1:0]       m_ready,
  output logic [XLEN-1:0]          m_dat_i,
  output logic                     bus_req,
  output logic                     bus_wen,
  output logic [2:0]               bus_mode,
  output logic [XLEN-1:0]          bus_addr,
  output logic [XLEN-1:0]          bus_dat_o,
  output logic [NUM_W-1:0]         bus_num,
  input  logic [XLEN-1:0]          bus_dat_i,
  input  logic                     bus_ready,
  output logic [NMASTER-1:0]       grant,
  output logic                     bus_err
);

  localparam int IDXW = (NMASTER > 1) ? $clog2(NMASTER) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [IDXW-1:0]    owner_q, owner_d;
  logic [IDXW-1:0]    last_q, last_d;
  logic [NMASTER-1:0] grant_q, grant_d;
  logic [IDXW-1:0]    pick;
  logic               any_req;
  logic               busy;
  logic               timeout_hit;
  logic               done;

  // First requester after the previous owner, wrapping mod NMASTER.
  always_comb begin
    pick    = last_q;
    any_req = 1'b0;
    for (int k = 1; k <= NMASTER; k++) begin
      if (!any_req && m_req[(int'(last_q) + k) % NMASTER]) begin
        any_req = 1'b1;
        pick    = IDXW'((int'(last_q) + k) % NMASTER);
      end
    end
  end

  assign busy = (state_q == BUSY);

`ifdef UIBI_ARB_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  assign timeout_hit = busy && !bus_ready && (tmo_q == 16'(TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (!busy) begin
      tmo_d = '0;
    end else if (!bus_ready) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign done = busy && (bus_ready || timeout_hit);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          owner_d = pick;
          grant_d = NMASTER'(1) << pick;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
          last_d  = owner_q;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDXW'(NMASTER - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  // Slave side is the owner's fields while BUSY, zero otherwise.
  always_comb begin
    bus_req   = busy && !timeout_hit;
    bus_wen   = busy && m_wen[owner_q];
    bus_mode  = busy ? m_mode[int'(owner_q)*3 +: 3] : '0;
    bus_addr  = busy ? m_addr[int'(owner_q)*XLEN +: XLEN] : '0;
    bus_dat_o = busy ? m_dat_o[int'(owner_q)*XLEN +: XLEN] : '0;
    bus_num   = busy ? m_num[int'(owner_q)*NUM_W +: NUM_W] : '0;
    m_ready   = '0;
    // A transaction aborted by reset never reports completion.
    if (done && !rst) begin
      m_ready[owner_q] = 1'b1;
    end
    m_dat_i = timeout_hit ? '1 : bus_dat_i;
    bus_err = timeout_hit;
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_uibi_arbiter.sv
// Directed testbench for uibi_arbiter (2 masters); timeout checks follow UIBI_ARB_TIMEOUT_EN.
module tb_uibi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req;
  logic [1:0]  m_wen;
  logic [5:0]  m_mode;
  logic [63:0] m_addr;
  logic [63:0] m_dat_o;
  logic [7:0]  m_num;
  logic [1:0]  m_ready;
  logic [31:0] m_dat_i;
  logic        bus_req;
  logic        bus_wen;
  logic [2:0]  bus_mode;
  logic [31:0] bus_addr;
  logic [31:0] bus_dat_o;
  logic [3:0]  bus_num;
  logic [31:0] bus_dat_i;
  logic        bus_ready;
  logic [1:0]  grant;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  uibi_arbiter #(.NMASTER(2), .XLEN(32), .NUM_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_wen(m_wen), .m_mode(m_mode), .m_addr(m_addr),
    .m_dat_o(m_dat_o), .m_num(m_num), .m_ready(m_ready), .m_dat_i(m_dat_i),
    .bus_req(bus_req), .bus_wen(bus_wen), .bus_mode(bus_mode), .bus_addr(bus_addr),
    .bus_dat_o(bus_dat_o), .bus_num(bus_num), .bus_dat_i(bus_dat_i),
    .bus_ready(bus_ready), .grant(grant), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_g;
    rst = 1'b1; m_req = '0; m_wen = '0; m_mode = '0; m_addr = '0;
    m_dat_o = '0; m_num = '0; bus_dat_i = '0; bus_ready = 1'b0;
    cyc(); cyc(); smp();
    chk("rst_grant", grant, 2'b00);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_m_ready", m_ready, 2'b00);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);

    // Single read by master 0
    cyc(); rst = 1'b0; m_req = 2'b01; m_addr[31:0] = 32'h0000_1000; smp();
    chk("rd_c0_bus_req", bus_req, 1'b0);
    cyc(); smp();
    chk("rd_c1_bus_req", bus_req, 1'b1);
    chk("rd_c1_grant", grant, 2'b01);
    chk("rd_c1_bus_addr", bus_addr, 32'h0000_1000);
    chk("rd_c1_m_ready", m_ready, 2'b00);
    cyc(); smp();
    chk("rd_c2_bus_req", bus_req, 1'b1);
    cyc(); bus_ready = 1'b1; bus_dat_i = 32'hDEAD_BEEF; smp();
    chk("rd_c3_m_ready", m_ready, 2'b01);
    chk("rd_c3_m_dat_i", m_dat_i, 32'hDEAD_BEEF);
    chk("rd_c3_bus_req", bus_req, 1'b1);
    cyc(); bus_ready = 1'b0; m_req = 2'b00; smp();
    chk("rd_c4_grant", grant, 2'b00);
    chk("rd_c4_bus_req", bus_req, 1'b0);

    // Contention after reset: 01,10,01,10 with bubbles
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; m_req = 2'b11; m_addr = {32'h2222_0000, 32'h1111_0000}; smp();
    chk("rr_idle_grant", grant, 2'b00);
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      cyc(); bus_ready = 1'b1; smp();
      chk($sformatf("rr%0d_grant", i), grant, exp_g);
      chk($sformatf("rr%0d_m_ready", i), m_ready, exp_g);
      chk($sformatf("rr%0d_bus_addr", i), bus_addr, (i % 2 == 0) ? 32'h1111_0000 : 32'h2222_0000);
      cyc(); bus_ready = 1'b0; if (i == 3) m_req = 2'b00; smp();
      chk($sformatf("rr%0d_bubble_grant", i), grant, 2'b00);
      chk($sformatf("rr%0d_bubble_req", i), bus_req, 1'b0);
    end

    // Isolation and write path: master 1 requests while master 0 owns the bus
    cyc(); m_req = 2'b01; m_wen = 2'b10; m_mode = {3'b010, 3'b000};
    m_dat_o = {32'h1234_5678, 32'h0}; m_num = {4'd3, 4'd0}; smp();
    cyc(); m_req = 2'b11; smp();
    chk("iso_grant0", grant, 2'b01);
    chk("iso_wen0", bus_wen, 1'b0);
    chk("iso_addr0", bus_addr, 32'h1111_0000);
    cyc(); bus_ready = 1'b1; bus_dat_i = 32'hCAFE_0001; smp();
    chk("iso_m_ready0", m_ready, 2'b01);
    cyc(); bus_ready = 1'b0; m_req = 2'b10; smp();
    chk("iso_bubble_grant", grant, 2'b00);
    chk("iso_bubble_m_ready", m_ready, 2'b00);
    chk("iso_bubble_req", bus_req, 1'b0);
    cyc(); smp();
    chk("wr_grant", grant, 2'b10);
    chk("wr_addr", bus_addr, 32'h2222_0000);
    chk("wr_wen", bus_wen, 1'b1);
    chk("wr_mode", bus_mode, 3'b010);
    chk("wr_dat", bus_dat_o, 32'h1234_5678);
    chk("wr_num", bus_num, 4'd3);
    cyc(); bus_ready = 1'b1; smp();
    chk("wr_m_ready", m_ready, 2'b10);
    cyc(); bus_ready = 1'b0; m_req = 2'b00; smp();
    chk("wr_after_wen", bus_wen, 1'b0);
    chk("wr_after_mode", bus_mode, 3'b000);
    chk("wr_after_grant", grant, 2'b00);

    // Reset mid-BUSY
    cyc(); m_req = 2'b10; smp();
    cyc(); smp();
    chk("mrst_grant", grant, 2'b10);
    chk("mrst_bus_req", bus_req, 1'b1);
    rst = 1'b1; bus_ready = 1'b1; #1;
    chk("mrst_no_m_ready", m_ready, 2'b00);
    cyc(); rst = 1'b0; bus_ready = 1'b0; m_req = 2'b11; smp();
    chk("mrst_after_req", bus_req, 1'b0);
    chk("mrst_after_grant", grant, 2'b00);
    cyc(); smp();
    chk("mrst_first_grant", grant, 2'b01);
    cyc(); bus_ready = 1'b1; smp();
    chk("mrst_m_ready", m_ready, 2'b01);
    cyc(); bus_ready = 1'b0; m_req = 2'b00; smp();

    // Stalled slave
    cyc(); m_req = 2'b01; bus_dat_i = 32'h0BAD_F00D; smp();
`ifdef UIBI_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      cyc(); smp();
      if (k < 8) begin
        chk($sformatf("tmo%0d_req", k), bus_req, 1'b1);
        chk($sformatf("tmo%0d_err", k), bus_err, 1'b0);
      end else begin
        chk("tmo_m_ready", m_ready, 2'b01);
        chk("tmo_m_dat_i", m_dat_i, 32'hFFFF_FFFF);
        chk("tmo_err", bus_err, 1'b1);
        chk("tmo_req", bus_req, 1'b0);
      end
    end
    cyc(); m_req = 2'b00; smp();
    chk("tmo_after_grant", grant, 2'b00);
    chk("tmo_after_err", bus_err, 1'b0);
`else
    for (int k = 1; k <= 120; k++) begin
      cyc(); smp();
      chk($sformatf("stall%0d_req", k), bus_req, 1'b1);
      chk($sformatf("stall%0d_err", k), bus_err, 1'b0);
    end
    cyc(); bus_ready = 1'b1; smp();
    chk("stall_m_ready", m_ready, 2'b01);
    chk("stall_m_dat_i", m_dat_i, 32'h0BAD_F00D);
    cyc(); bus_ready = 1'b0; m_req = 2'b00; smp();
    chk("stall_after_grant", grant, 2'b00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
